// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV64 control unit.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_R       = 3'd0,
        C_IALU    = 3'd1,
        C_LOAD    = 3'd2,
        C_STORE   = 3'd3,
        C_BRANCH  = 3'd4,
        C_ILLEGAL = 3'd5
    } class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    // {alu_src, alu_op} used by a class while its operands are in the ALU
    function automatic logic [2:0] alu_ctl(input class_t c);
        logic [2:0] v;
        v = {1'b0, ALU_ADD};
        case (c)
            C_R:      v = {1'b0, ALU_R};
            C_IALU:   v = {1'b1, ALU_I};
            C_LOAD:   v = {1'b1, ALU_ADD};
            C_STORE:  v = {1'b1, ALU_ADD};
            C_BRANCH: v = {1'b0, ALU_BR};
            default:  v = {1'b0, ALU_ADD};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct3 to class.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output class_t     o_class,
    output logic       o_illegal
);

    logic w_br_ok;

    assign w_br_ok = (i_funct3 == F3_BEQ) || (i_funct3 == F3_BGE);

    always_comb begin
        o_class = C_ILLEGAL;
        unique case (1'b1)
            (i_opcode == OP_R):                 o_class = C_R;
            (i_opcode == OP_IALU):              o_class = C_IALU;
            (i_opcode == OP_LOAD):              o_class = C_LOAD;
            (i_opcode == OP_STORE):             o_class = C_STORE;
            (i_opcode == OP_BRANCH && w_br_ok): o_class = C_BRANCH;
            default:                            o_class = C_ILLEGAL;
        endcase
    end

    assign o_illegal = (o_class == C_ILLEGAL);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV64
// datapath, with memory handshakes and a retired-instruction counter.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             ge_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    class_t           w_dec_class;
    logic             w_dec_illegal;
    logic             w_taken;
    logic [CNT_W-1:0] r_instret;

    ctrl_decode u_dec (
        .i_opcode  (opcode),
        .i_funct3  (funct3),
        .o_class   (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

    assign w_taken = (funct3 == F3_BGE) ? ge_zero : zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_class   <= C_R;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_class <= w_dec_class;
            if (pc_write && !illegal)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec_illegal) begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                {alu_src, alu_op} = alu_ctl(r_class);
                case (r_class)
                    C_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = w_taken;
                        w_next   = S_FETCH;
                    end
                    C_LOAD, C_STORE: w_next = S_MEM;
                    default:         w_next = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                alu_src = 1'b1;
                alu_op  = ALU_ADD;
                if (r_class == C_LOAD) begin
                    mem_read = 1'b1;
                    if (dmem_ready)
                        w_next = S_WRITEBACK;
                end else begin
                    mem_write = 1'b1;
                    if (dmem_ready) begin
                        pc_write = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write         = 1'b1;
                mem_to_reg        = (r_class == C_LOAD);
                {alu_src, alu_op} = alu_ctl(r_class);
                pc_write          = 1'b1;
                w_next            = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // an access in flight when reset arrives is dropped, not completed
        if (reset) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one 64-bit counter instance
// and one 4-bit instance driven by the same stimulus.
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        ge_zero;
    logic        imem_ready;
    logic        dmem_ready;

    logic        imem_req, ir_write, pc_write, pc_src, reg_write;
    logic        mem_read, mem_write, mem_to_reg, alu_src, illegal;
    logic [1:0]  alu_op;
    logic [63:0] instret;
    logic [2:0]  state;

    logic        n_imem_req, n_ir_write, n_pc_write, n_pc_src, n_reg_write;
    logic        n_mem_read, n_mem_write, n_mem_to_reg, n_alu_src, n_illegal;
    logic [1:0]  n_alu_op;
    logic [3:0]  n_instret;
    logic [2:0]  n_state;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control_fsm #(.CNT_W(64)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .zero(zero), .ge_zero(ge_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .alu_op(alu_op), .illegal(illegal), .instret(instret),
        .state(state)
    );

    multicycle_control_fsm #(.CNT_W(4)) u_narrow (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .zero(zero), .ge_zero(ge_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(n_imem_req), .ir_write(n_ir_write),
        .pc_write(n_pc_write), .pc_src(n_pc_src),
        .reg_write(n_reg_write), .mem_read(n_mem_read),
        .mem_write(n_mem_write), .mem_to_reg(n_mem_to_reg),
        .alu_src(n_alu_src), .alu_op(n_alu_op), .illegal(n_illegal),
        .instret(n_instret), .state(n_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    // ctl = {imem_req, ir_write, pc_write, pc_src, reg_write,
    //        mem_read, mem_write, mem_to_reg, alu_src}
    task automatic ck(input string tag, input logic [2:0] st,
                      input logic [8:0] ctl, input logic [1:0] aop,
                      input logic il);
        logic [14:0] o;
        logic [14:0] e;
        #1;
        o = {state, imem_req, ir_write, pc_write, pc_src, reg_write,
             mem_read, mem_write, mem_to_reg, alu_src, alu_op, illegal};
        e = {st, ctl, aop, il};
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic ckc(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fetch_decode(input string tag);
        ck({tag, ".F"}, 3'd0, 9'b110000000, 2'b00, 1'b0);
        nx();
        ck({tag, ".D"}, 3'd1, 9'b000000000, 2'b00, 1'b0);
        nx();
    endtask

    initial begin
        reset      = 1'b1;
        opcode     = 7'b0000000;
        funct3     = 3'b000;
        zero       = 1'b0;
        ge_zero    = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        nx();
        nx();
        // ready is high but reset suppresses ir_write
        ck("rst", 3'd0, 9'b100000000, 2'b00, 1'b0);
        ckc("rst.instret", instret, 64'd0);
        ckc("rst.instret4", 64'(n_instret), 64'd0);
        reset = 1'b0;

        // add x3,x1,x2
        opcode = 7'b0110011;
        fetch_decode("add");
        ck("add.E", 3'd2, 9'b000000000, 2'b10, 1'b0);
        nx();
        ck("add.W", 3'd4, 9'b001010000, 2'b10, 1'b0);
        ckc("add.pre", instret, 64'd0);
        nx();
        ckc("add.instret", instret, 64'd1);

        // ld with three cycles of dmem wait
        opcode     = 7'b0000011;
        funct3     = 3'b011;
        dmem_ready = 1'b0;
        fetch_decode("ld");
        ck("ld.E", 3'd2, 9'b000000001, 2'b00, 1'b0);
        nx();
        for (int i = 0; i < 3; i++) begin
            ck("ld.Mwait", 3'd3, 9'b000001001, 2'b00, 1'b0);
            nx();
        end
        dmem_ready = 1'b1;
        ck("ld.M", 3'd3, 9'b000001001, 2'b00, 1'b0);
        nx();
        ck("ld.W", 3'd4, 9'b001010011, 2'b00, 1'b0);
        nx();
        ckc("ld.instret", instret, 64'd2);

        // beq taken / not taken
        opcode  = 7'b1100011;
        funct3  = 3'b000;
        zero    = 1'b1;
        ge_zero = 1'b0;
        fetch_decode("beqT");
        ck("beqT.E", 3'd2, 9'b001100000, 2'b01, 1'b0);
        nx();
        ckc("beqT.instret", instret, 64'd3);
        zero = 1'b0;
        fetch_decode("beqN");
        ck("beqN.E", 3'd2, 9'b001000000, 2'b01, 1'b0);
        nx();
        ckc("beqN.instret", instret, 64'd4);

        // bge follows ge_zero, not zero
        funct3  = 3'b101;
        ge_zero = 1'b1;
        fetch_decode("bge");
        ck("bge.E", 3'd2, 9'b001100000, 2'b01, 1'b0);
        nx();
        ckc("bge.instret", instret, 64'd5);
        ge_zero = 1'b0;

        // unsupported branch funct3
        funct3 = 3'b001;
        ck("bad.F", 3'd0, 9'b110000000, 2'b00, 1'b0);
        nx();
        ck("bad.D", 3'd1, 9'b001000000, 2'b00, 1'b1);
        nx();
        ckc("bad.instret", instret, 64'd5);

        // all-ones opcode: single-cycle illegal pulse
        opcode = 7'b1111111;
        funct3 = 3'b000;
        ck("ill.F", 3'd0, 9'b110000000, 2'b00, 1'b0);
        nx();
        ck("ill.D", 3'd1, 9'b001000000, 2'b00, 1'b1);
        nx();
        imem_ready = 1'b0;
        ck("ill.after", 3'd0, 9'b100000000, 2'b00, 1'b0);
        ckc("ill.instret", instret, 64'd5);
        imem_ready = 1'b1;

        // addi
        opcode = 7'b0010011;
        fetch_decode("addi");
        ck("addi.E", 3'd2, 9'b000000001, 2'b11, 1'b0);
        nx();
        ck("addi.W", 3'd4, 9'b001010001, 2'b11, 1'b0);
        nx();
        ckc("addi.instret", instret, 64'd6);

        // sd with an imem stall first
        opcode     = 7'b0100011;
        funct3     = 3'b011;
        imem_ready = 1'b0;
        ck("sd.Fstall", 3'd0, 9'b100000000, 2'b00, 1'b0);
        nx();
        imem_ready = 1'b1;
        fetch_decode("sd");
        ck("sd.E", 3'd2, 9'b000000001, 2'b00, 1'b0);
        nx();
        ck("sd.M", 3'd3, 9'b001000101, 2'b00, 1'b0);
        nx();
        ckc("sd.instret", instret, 64'd7);
        ckc("sd.instret4", 64'(n_instret), 64'd7);

        // reset arriving in MEM of a store with dmem_ready high
        fetch_decode("sdr");
        ck("sdr.E", 3'd2, 9'b000000001, 2'b00, 1'b0);
        nx();
        reset = 1'b1;
        ck("sdr.Mrst", 3'd3, 9'b000000001, 2'b00, 1'b0);
        nx();
        ck("sdr.after", 3'd0, 9'b100000000, 2'b00, 1'b0);
        ckc("sdr.instret", instret, 64'd0);
        ckc("sdr.instret4", 64'(n_instret), 64'd0);
        reset = 1'b0;

        // 16 not-taken branches: 4-bit counter wraps
        opcode = 7'b1100011;
        funct3 = 3'b000;
        zero   = 1'b0;
        for (int k = 0; k < 15; k++) begin
            nx();
            nx();
            nx();
        end
        ckc("wrap.15", 64'(n_instret), 64'd15);
        nx();
        nx();
        nx();
        ckc("wrap.16", 64'(n_instret), 64'd0);
        ckc("wide.16", instret, 64'd16);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
